// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Moore-style main control FSM for the multicycle MIPS-subset datapath.
// It steps through fetch, decode, execute, memory and writeback, one state
// per clock. In each state it drives the datapath mux selects, the write
// enables and the 2-bit ALUOp used by the ALU decoder.
//
// Optional build macro:
//   BNE_SUPPORT_EN  - adds bne (opcode 6'h05) through state BRANCH_NE (12).
//                     When the macro is undefined, 6'h05 is illegal and
//                     code 12 is an unused state.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-high; State goes to FETCH
//   Op        in   opcode taken from the instruction register
//   Zero      in   ALU zero flag; affects PCEn only
//   MemWrite  out  data memory write enable
//   IRWrite   out  instruction register load
//   RegWrite  out  register file write enable
//   PCEn      out  PC load = PCWrite | (Branch & Zero) [| (BranchNE & ~Zero)]
//   IorD      out  memory address select (0 = PC, 1 = ALUOut)
//   RegDst    out  write register select (0 = rt, 1 = rd)
//   MemtoReg  out  writeback select (0 = ALUOut, 1 = Data)
//   ALUSrcA   out  ALU A select (0 = PC, 1 = A)
//   ALUSrcB   out  ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   PCSrc     out  next-PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   ALUOp     out  ALU decoder control (00 add, 01 sub, 10 funct)
//   Illegal   out  one-cycle pulse in DECODE for an unsupported opcode
//   State     out  current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int          STATE_W  = 4,
   parameter logic [5:0]  OP_LW    = 6'h23,
   parameter logic [5:0]  OP_SW    = 6'h2B,
   parameter logic [5:0]  OP_RTYPE = 6'h00,
   parameter logic [5:0]  OP_BEQ   = 6'h04,
   parameter logic [5:0]  OP_ADDI  = 6'h08,
   parameter logic [5:0]  OP_J     = 6'h02
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         Op,
   input  logic               Zero,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               PCEn,
   output logic               IorD,
   output logic               RegDst,
   output logic               MemtoReg,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSrc,
   output logic [1:0]         ALUOp,
   output logic               Illegal,
   output logic [STATE_W-1:0] State
);

`ifdef BNE_SUPPORT_EN
   localparam logic [5:0] OP_BNE = 6'h05;
`endif

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = STATE_W'(0),
      S_DECODE    = STATE_W'(1),
      S_MEMADR    = STATE_W'(2),
      S_MEMRD     = STATE_W'(3),
      S_MEMWB     = STATE_W'(4),
      S_MEMWR     = STATE_W'(5),
      S_EXECUTE   = STATE_W'(6),
      S_ALUWB     = STATE_W'(7),
      S_BRANCH    = STATE_W'(8),
      S_ADDIEXEC  = STATE_W'(9),
      S_ADDIWB    = STATE_W'(10),
`ifdef BNE_SUPPORT_EN
      S_JUMP      = STATE_W'(11),
      S_BRANCH_NE = STATE_W'(12)
`else
      S_JUMP      = STATE_W'(11)
`endif
   } state_t;

   state_t state_q;
   state_t state_d;

   // Internal branch/PC-write terms that are folded into PCEn.
   logic pc_write;
   logic branch;
   logic branch_ne;

   // Supported opcode check, shared by next-state and Illegal logic.
   function automatic logic op_supported(input logic [5:0] op);
      logic ok;
      ok = (op == OP_LW)   || (op == OP_SW)   || (op == OP_RTYPE) ||
           (op == OP_BEQ)  || (op == OP_ADDI) || (op == OP_J);
`ifdef BNE_SUPPORT_EN
      ok = ok || (op == OP_BNE);
`endif
      return ok;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. Unused codes fall through to FETCH.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            if ((Op == OP_LW) || (Op == OP_SW)) begin
               state_d = S_MEMADR;
            end else if (Op == OP_RTYPE) begin
               state_d = S_EXECUTE;
            end else if (Op == OP_BEQ) begin
               state_d = S_BRANCH;
            end else if (Op == OP_ADDI) begin
               state_d = S_ADDIEXEC;
            end else if (Op == OP_J) begin
               state_d = S_JUMP;
`ifdef BNE_SUPPORT_EN
            end else if (Op == OP_BNE) begin
               state_d = S_BRANCH_NE;
`endif
            end else begin
               // Unsupported opcode: abandon the instruction with no writes.
               state_d = S_FETCH;
            end
         end
         // Only lw and sw reach MEMADR, so anything that is not lw is a store.
         S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    state_d = S_MEMWB;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // Moore outputs, decoded from the current state only. Zero enters
   // solely through PCEn. Reset then overrides the decoded values so the
   // aborted instruction cannot write anything in the reset cycle.
   always_comb begin
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      IorD      = 1'b0;
      RegDst    = 1'b0;
      MemtoReg  = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'b00;
      PCSrc     = 2'b00;
      ALUOp     = 2'b00;
      Illegal   = 1'b0;
      pc_write  = 1'b0;
      branch    = 1'b0;
      branch_ne = 1'b0;

      case (state_q)
         S_FETCH: begin
            IRWrite  = 1'b1;
            pc_write = 1'b1;
            ALUSrcB  = 2'b01;
            ALUOp    = 2'b00;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            ALUOp   = 2'b00;
            Illegal = ~op_supported(Op);
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            IorD = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
         end
         S_JUMP: begin
            PCSrc    = 2'b10;
            pc_write = 1'b1;
         end
`ifdef BNE_SUPPORT_EN
         S_BRANCH_NE: begin
            ALUSrcA   = 1'b1;
            ALUOp     = 2'b01;
            PCSrc     = 2'b01;
            branch_ne = 1'b1;
         end
`endif
         default: begin
            // Unused codes keep every output at 0.
         end
      endcase

      PCEn = pc_write | (branch & Zero) | (branch_ne & ~Zero);

      if (reset) begin
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         PCEn     = 1'b0;
         Illegal  = 1'b0;
         IorD     = 1'b0;
         RegDst   = 1'b0;
         MemtoReg = 1'b0;
         ALUSrcA  = 1'b0;
         ALUSrcB  = 2'b01;
         PCSrc    = 2'b00;
         ALUOp    = 2'b00;
      end
   end

   assign State = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Drives directed instructions, then a random instruction stream, and
// compares every cycle's State and control outputs with a reference model
// built from the per-instruction state sequences and per-state output table.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   logic       clk;
   logic       reset;
   logic [5:0] Op;
   logic       Zero;
   logic       MemWrite, IRWrite, RegWrite, PCEn, IorD, RegDst, MemtoReg;
   logic       ALUSrcA, Illegal;
   logic [1:0] ALUSrcB, PCSrc, ALUOp;
   logic [3:0] State;

   int total  = 0;
   int passed = 0;
   int failed = 0;
   int seq[$];

   multicycle_controller dut (
      .clk      (clk),
      .reset    (reset),
      .Op       (Op),
      .Zero     (Zero),
      .MemWrite (MemWrite),
      .IRWrite  (IRWrite),
      .RegWrite (RegWrite),
      .PCEn     (PCEn),
      .IorD     (IorD),
      .RegDst   (RegDst),
      .MemtoReg (MemtoReg),
      .ALUSrcA  (ALUSrcA),
      .ALUSrcB  (ALUSrcB),
      .PCSrc    (PCSrc),
      .ALUOp    (ALUOp),
      .Illegal  (Illegal),
      .State    (State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {State, MemWrite, IRWrite, RegWrite, PCEn, IorD, RegDst, MemtoReg,
   //  ALUSrcA, ALUSrcB, PCSrc, ALUOp, Illegal}
   logic [18:0] obs;
   assign obs = {State, MemWrite, IRWrite, RegWrite, PCEn, IorD, RegDst,
                 MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUOp, Illegal};

   function automatic logic legal(input logic [5:0] op);
      logic ok;
      ok = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) ||
           (op == 6'h04) || (op == 6'h08) || (op == 6'h02);
`ifdef BNE_SUPPORT_EN
      ok = ok || (op == 6'h05);
`endif
      return ok;
   endfunction

   // State sequence an instruction walks through, starting at FETCH.
   task automatic build_seq(input logic [5:0] op);
      seq.delete();
      seq.push_back(0);
      seq.push_back(1);
      case (op)
         6'h23: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
         6'h2B: begin seq.push_back(2); seq.push_back(5); end
         6'h00: begin seq.push_back(6); seq.push_back(7); end
         6'h04: seq.push_back(8);
         6'h08: begin seq.push_back(9); seq.push_back(10); end
         6'h02: seq.push_back(11);
`ifdef BNE_SUPPORT_EN
         6'h05: seq.push_back(12);
`endif
         default: ;
      endcase
   endtask

   // Output table: what each state is documented to drive.
   function automatic logic [18:0] exp_vec(input int st, input logic z,
                                           input logic [5:0] op);
      logic mw = 0, irw = 0, rw = 0, pcen = 0, iord = 0, rdst = 0, m2r = 0;
      logic sa = 0, ill = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00, ao = 2'b00;
      case (st)
         0:  begin irw = 1; pcen = 1; sb = 2'b01; end
         1:  begin sb = 2'b11; ill = !legal(op); end
         2:  begin sa = 1; sb = 2'b10; end
         3:  iord = 1;
         4:  begin m2r = 1; rw = 1; end
         5:  begin iord = 1; mw = 1; end
         6:  begin sa = 1; ao = 2'b10; end
         7:  begin rdst = 1; rw = 1; end
         8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pcen = z; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin ps = 2'b10; pcen = 1; end
`ifdef BNE_SUPPORT_EN
         12: begin sa = 1; ao = 2'b01; ps = 2'b01; pcen = !z; end
`endif
         default: ;
      endcase
      return {4'(st), mw, irw, rw, pcen, iord, rdst, m2r, sa, sb, ps, ao, ill};
   endfunction

   // While reset is high: FETCH selects, no enables, no Illegal.
   function automatic logic [18:0] rst_vec(input int st);
      return {4'(st), 8'b0, 2'b01, 2'b00, 2'b00, 1'b0};
   endfunction

   task automatic chk(input string tag, input int step, input logic [18:0] want);
      total++;
      assert (obs === want) passed++;
      else begin
         failed++;
         $error("FAIL %s step%0d: observed %05h expected %05h", tag, step, obs, want);
      end
   endtask

   // Runs the first n cycles of an instruction. zmode < 0 randomizes Zero.
   task automatic run_part(input string tag, input logic [5:0] op,
                           input int n, input int zmode);
      build_seq(op);
      Op = op;
      for (int i = 0; i < n && i < seq.size(); i++) begin
         Zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
         #1;
         chk(tag, i, exp_vec(seq[i], Zero, op));
         @(posedge clk);
         #1;
      end
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input int zmode);
      run_part(tag, op, 16, zmode);
   endtask

   // Reset asserted in the current state: outputs forced, then FETCH.
   task automatic abort_in(input string tag, input int st);
      reset = 1'b1;
      #1;
      chk(tag, 0, rst_vec(st));
      @(posedge clk);
      #1;
      chk(tag, 1, rst_vec(0));
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] op;
      int         r;
      reset = 1'b1;
      Op    = 6'h00;
      Zero  = 1'b0;

      // Two reset cycles
      @(posedge clk);
      #1;
      chk("reset0", 0, rst_vec(0));
      @(posedge clk);
      #1;
      chk("reset1", 0, rst_vec(0));
      reset = 1'b0;

      // Directed instructions
      run_instr("lw",       6'h23, -1);
      run_instr("sw",       6'h2B, -1);
      run_instr("rtype",    6'h00, -1);
      run_instr("beq_z1",   6'h04, 1);
      run_instr("beq_z0",   6'h04, 0);
      run_instr("j",        6'h02, -1);
      run_instr("addi",     6'h08, -1);
      run_instr("illegal",  6'h3F, -1);
      run_instr("op05_z0",  6'h05, 0);
      run_instr("op05_z1",  6'h05, 1);

      // Reset during MEMRD and during MEMWB of a load
      run_part("lw_pre3", 6'h23, 3, -1);
      abort_in("rst_in_s3", 3);
      run_part("lw_pre4", 6'h23, 4, -1);
      abort_in("rst_in_s4", 4);
      run_instr("after_abort", 6'h00, -1);

      // Random instruction stream
      for (int k = 0; k < 80; k++) begin
         r = $urandom_range(0, 7);
         case (r)
            0: op = 6'h23;
            1: op = 6'h2B;
            2: op = 6'h00;
            3: op = 6'h04;
            4: op = 6'h08;
            5: op = 6'h02;
            6: op = 6'h05;
            default: op = 6'($urandom);
         endcase
         run_instr("rand", op, -1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
